// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and types for the 256x128 RAM-backed FIFO controller
// and its storage macro.
package nv_ram_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 256;  // RAM entries
  localparam int unsigned FIFO_WIDTH = 128;  // payload bits
  localparam int unsigned PTR_W      = 8;    // RAM address width
  localparam int unsigned CNT_W      = 9;    // occupancy count width (0..258)
  localparam int unsigned SKID_DEPTH = 2;    // output skid entries

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [FIFO_WIDTH-1:0] data_t;

endpackage

// File: rtl/nv_ram_rws_256x128.sv
// 256x128 single-clock RAM, one write port and one registered read port.
// Read data appears on dout one cycle after re; dout holds otherwise.
// Ports:
//   clk           clock
//   ra / re       read address / read enable
//   dout          read data (registered)
//   wa / we / di  write address / write enable / write data
//   pwrbus_ram_pd power-control bus (unused by this behavioural model)
module nv_ram_rws_256x128
  import nv_ram_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic [PTR_W-1:0]      ra,
  input  logic                  re,
  output logic [FIFO_WIDTH-1:0] dout,
  input  logic [PTR_W-1:0]      wa,
  input  logic                  we,
  input  logic [FIFO_WIDTH-1:0] di,
  input  logic [31:0]           pwrbus_ram_pd
);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] r_dout;
  logic                  w_unused_pwr;

  assign w_unused_pwr = ^pwrbus_ram_pd;

  // Read samples the array before a same-edge write, so a write to the
  // address being read returns the old contents.
  always_ff @(posedge clk) begin
    if (we) r_mem[wa] <= di;
    if (re) r_dout    <= r_mem[ra];
  end

  assign dout = r_dout;

endmodule

// File: rtl/nv_ram_fifo_ctrl_256x128.sv
// FIFO controller: 256-entry RAM store plus a 2-entry output skid so a
// continuously ready consumer sees one entry per cycle despite the RAM's
// one-cycle read latency. Total capacity is 258.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_pvld/prdy   write handshake, wr_pd write payload
//   rd_pvld/prdy   read handshake, rd_pd skid head (0 when empty)
//   fifo_cnt       entries held (RAM + in-flight read + skid)
//   idle           fifo_cnt == 0
//   pwrbus_ram_pd  passed through to the RAM
module nv_ram_fifo_ctrl_256x128
  import nv_ram_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             idle,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_ram_cnt;
  logic [1:0]       r_skid_cnt;
  logic             r_rd_inflight;
  logic [WIDTH-1:0] r_skid     [SKID_DEPTH];
  logic [WIDTH-1:0] w_skid_nxt [SKID_DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [2:0]       w_skid_load;
  logic             w_tail;
  logic             w_ram_we;
  logic             w_ram_re;
  logic [WIDTH-1:0] w_ram_dout;

  assign wr_prdy = (r_ram_cnt < CNT_W'(DEPTH));
  assign rd_pvld = (r_skid_cnt != 2'd0);
  assign rd_pd   = rd_pvld ? r_skid[0] : '0;
  assign fifo_cnt = r_ram_cnt + CNT_W'(r_rd_inflight) + CNT_W'(r_skid_cnt);
  assign idle    = (fifo_cnt == '0);

  assign w_push = wr_pvld & wr_prdy;
  assign w_pop  = rd_pvld & rd_prdy;

  // Skid slots committed after this cycle, counting the read already in
  // flight; issue only if that leaves room for the new read's data.
  assign w_skid_load = 3'(r_skid_cnt) + 3'(r_rd_inflight) - 3'(w_pop);
  assign w_issue     = (r_ram_cnt != '0) && (w_skid_load < 3'(SKID_DEPTH));

  assign w_ram_we = w_push  & ~rst;
  assign w_ram_re = w_issue & ~rst;

  // Slot receiving captured RAM data: position after the post-pop shift.
  // skid_cnt==2 with a capture always coincides with a pop.
  assign w_tail = r_skid_cnt[1] | (r_skid_cnt[0] & ~w_pop);

  always_comb begin
    w_skid_nxt = r_skid;
    if (w_pop) w_skid_nxt[0] = r_skid[1];
    if (r_rd_inflight) w_skid_nxt[w_tail] = w_ram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_cnt     <= '0;
      r_skid_cnt    <= '0;
      r_rd_inflight <= 1'b0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) r_skid[i] <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt     <= r_ram_cnt + CNT_W'(w_push) - CNT_W'(w_issue);
      r_skid_cnt    <= r_skid_cnt + 2'(r_rd_inflight) - 2'(w_pop);
      r_rd_inflight <= w_issue;
      r_skid        <= w_skid_nxt;
    end
  end

  nv_ram_rws_256x128 u_ram (
    .clk           (clk),
    .ra            (r_rd_ptr),
    .re            (w_ram_re),
    .dout          (w_ram_dout),
    .wa            (r_wr_ptr),
    .we            (w_ram_we),
    .di            (wr_pd),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

endmodule

// File: doc/nv_ram_fifo_ctrl_256x128.md
NV_RAM_FIFO_CTRL_256X128 -- requirements
Module: nv_ram_fifo_ctrl_256x128

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning RAM entries; fixed at 256.
REQ-002 SHALL have parameter WIDTH, default 128, meaning payload bits; fixed at 128.
REQ-003 SHALL have port clk  in  1  sole clock; all flops rise-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_pvld  in  1  write payload valid.
REQ-006 SHALL have port wr_prdy  out  1  write ready; high iff RAM occupancy (ram_cnt) < 256.
REQ-007 SHALL have port wr_pd  in  128  write payload.
REQ-008 SHALL have port rd_pvld  out  1  read payload valid; high iff skid occupancy (skid_cnt) > 0.
REQ-009 SHALL have port rd_prdy  in  1  read ready.
REQ-010 SHALL have port rd_pd  out  128  skid head entry; 0 when empty.
REQ-011 SHALL have port fifo_cnt  out  9  ram_cnt + rd_inflight + skid_cnt.
REQ-012 SHALL have port idle  out  1  high iff fifo_cnt == 0.
REQ-013 SHALL have port pwrbus_ram_pd  in  32  passed unmodified to the RAM.

Function
REQ-014 SHALL accept a write in every cycle with wr_pvld & wr_prdy: RAM we=1, wa=wr_ptr, di=wr_pd; wr_ptr += 1 mod 256.
REQ-015 SHALL issue a RAM read (re=1, ra=rd_ptr; rd_ptr += 1 mod 256; ram_cnt -= 1; rd_inflight <= 1) when ram_cnt != 0 and (skid_cnt + rd_inflight - pop) < 2, where pop = rd_pvld & rd_prdy.
REQ-016 SHALL capture RAM dout into the skid tail in the cycle after issue, i.e. while rd_inflight == 1; RAM read latency is exactly 1 cycle.
REQ-017 SHALL hold a 2-entry skid so a continuous pop sustains 1 entry/cycle with no bubbles.
REQ-018 SHALL give write-to-rd_pvld latency of 3 cycles into an empty FIFO: accept at N, read issue at N+1, capture at N+2, rd_pvld high at N+3.
REQ-019 SHALL apply a same-cycle push, issue and pop together: ram_cnt += push - issue; skid_cnt += capture - pop.
REQ-020 SHALL treat a freed RAM slot as writable only from the cycle after its read issue; a wrap write landing on the edge that captures dout SHALL leave the captured data as the old value.
REQ-021 SHALL have total capacity 258; wr_prdy is unaffected by skid state.
REQ-022 SHALL ignore wr_pd when wr_prdy is low; a write attempted while full is dropped and is the producer's error.
REQ-023 SHALL hold rd_pd stable while rd_pvld & !rd_prdy.

Reset
REQ-024 SHALL, while rst is high, force wr_ptr, rd_ptr, ram_cnt, skid_cnt and rd_inflight to 0; this gives wr_prdy=1, rd_pvld=0, rd_pd=0, fifo_cnt=0, idle=1.
REQ-025 SHALL discard all in-flight and stored data on reset mid-operation and not clear RAM contents.
REQ-026 SHALL drive we=0 and re=0 to the RAM while rst is high.

Structure
REQ-027 SHALL place DEPTH, WIDTH, the pointer width (8), the count width (9) and the skid depth (2) in shared package nv_ram_fifo_pkg.
REQ-028 SHALL instantiate exactly one sub-module, nv_ram_rws_256x128, as storage; the skid and control logic are local.

Verification
REQ-029 SHALL test single entry: reset, push 128'hA5 at cycle 0 with rd_prdy=0 -> rd_pvld rises at cycle 3 with rd_pd=128'hA5, fifo_cnt=1.
REQ-030 SHALL test fill: push 258 entries with rd_prdy=0 -> wr_prdy low after 258 accepts, fifo_cnt=258, and a 259th push is not accepted.
REQ-031 SHALL test streaming: continuous push 0..999 with rd_prdy=1 -> output 0..999 in order with no gaps after the first rd_pvld.
REQ-032 SHALL test wrap at full: fill to 258, pop one, push X the next cycle -> X is written at the just-freed address and the popped data is unchanged.
REQ-033 SHALL test random backpressure: random wr_pvld/rd_prdy for 10k cycles -> scoreboard order matches, fifo_cnt matches the model, and rd_pd is stable under stall.
REQ-034 SHALL test mid-stream reset: assert rst with fifo_cnt=100 -> next cycle idle=1 and rd_pvld=0; a push of 128'h1 then reads back 128'h1.
